// File: rtl/generic_lb_pkg.sv
// Shared types and elaboration-time helpers for the pyramid-filter line buffer.
package generic_lb_pkg;

   typedef enum logic {
      FILL   = 1'b0,
      STREAM = 1'b1
   } lb_state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // 1R1W banks can reuse the oldest line's bank for the write; 1RW banks need a spare.
   function automatic int nb_calc(input int r1w1, input int no_lines);
      return (r1w1 != 0) ? no_lines : no_lines + 1;
   endfunction

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/generic_lb_bank_rams.sv
// Line-buffer bank primitives: a 1R1W RAM returning old data on collision,
// and a 1RW RAM. Both hold rdata while no read is issued.
module generic_dual_port_ram #(
   parameter int DW = 12,
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
      if (we) mem[waddr] <= wdata;
   end

endmodule

module generic_single_port_ram_wrapper #(
   parameter int DW = 12,
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/generic_lb_tap_rotator.sv
// Maps the NB bank read ports onto taps 1..NO_LINES using the write bank
// latched with the beat, so the selection lines up with the 1-cycle bank read.
module generic_lb_tap_rotator #(
   parameter int NB       = 4,
   parameter int NO_LINES = 4,
   parameter int DW       = 12,
   parameter int BW       = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [BW-1:0]          sel,
   input  logic [NB*DW-1:0]       bank_data,
   output logic [NO_LINES*DW-1:0] taps
);

   logic [BW-1:0] sel_q;

   function automatic int bank_idx(input logic [BW-1:0] s, input int n);
      int t;
      t = int'(s) + NB - n;
      if (t >= NB) t = t - NB;
      return t;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    sel_q <= '0;
      else if (load) sel_q <= sel;
   end

   always_comb begin
      taps = '0;
      for (int n = 1; n <= NO_LINES; n++) begin
         taps[(n-1)*DW +: DW] = bank_data[bank_idx(sel_q, n)*DW +: DW];
      end
   end

endmodule

// File: rtl/generic_line_buffer_ctrl.sv
// Streaming multi-line buffer: one pixel in per beat, one vertical column of
// NO_LINES+1 pixels out, with bank rotation, priming and a one-entry output stage.
//
// state  | meaning
// FILL   | priming after reset/sof; beats stored but not presented
// STREAM | enough lines stored; every accepted beat is presented
module generic_line_buffer_ctrl
   import generic_lb_pkg::*;
#(
   parameter int R1W1     = 1,
   parameter int NO_LINES = 4,
   parameter int DW       = 12,
   parameter int AW       = 11,
   parameter int IMG_W    = 1920
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sof,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DW-1:0]              in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [(NO_LINES+1)*DW-1:0] out_data,
   output logic                       out_eol
);

   localparam int NB = nb_calc(R1W1, NO_LINES);
   localparam int BW = idx_w(NB);
   localparam int LW = idx_w(NO_LINES + 1);
   localparam logic [AW-1:0] COL_LAST  = AW'(IMG_W - 1);
   localparam logic [LW-1:0] LINE_FULL = LW'(NO_LINES);
   localparam logic [BW-1:0] BANK_LAST = BW'(NB - 1);

   lb_state_t state, state_nxt, state_eff;
   logic [AW-1:0] col, col_eff, col_nxt;
   logic [LW-1:0] line_cnt, line_eff, line_nxt;
   logic [BW-1:0] wr_bank, bank_eff, bank_nxt;
   logic          rdy_en, acc, present, eol_in;
   logic [DW-1:0] data_q;
   logic          eol_q;
   logic [NB*DW-1:0]       bank_rd;
   logic [NO_LINES*DW-1:0] taps;

   assign in_ready = rdy_en & (~out_valid | out_ready);
   assign acc      = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FILL;
      else        state <= state_nxt;
   end

   // sof takes effect in its own cycle so a coincident beat becomes pixel (0,0).
   always_comb begin
      state_eff = sof ? FILL : state;
      col_eff   = sof ? '0 : col;
      line_eff  = sof ? '0 : line_cnt;
      bank_eff  = sof ? '0 : wr_bank;
      present   = (state_eff == STREAM) || ((line_eff == LINE_FULL) && (col_eff == '0));
      eol_in    = (col_eff == COL_LAST);
      state_nxt = state_eff;
      col_nxt   = col_eff;
      line_nxt  = line_eff;
      bank_nxt  = bank_eff;
      if (acc) begin
         if (present) state_nxt = STREAM;
         if (eol_in) begin
            col_nxt  = '0;
            bank_nxt = (bank_eff == BANK_LAST) ? '0 : bank_eff + 1'b1;
            if (line_eff != LINE_FULL) line_nxt = line_eff + 1'b1;
         end else begin
            col_nxt = col_eff + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en    <= 1'b0;
         out_valid <= 1'b0;
         data_q    <= '0;
         eol_q     <= 1'b0;
         col       <= '0;
         line_cnt  <= '0;
         wr_bank   <= '0;
      end else begin
         rdy_en   <= 1'b1;
         col      <= col_nxt;
         line_cnt <= line_nxt;
         wr_bank  <= bank_nxt;
         if (acc) begin
            out_valid <= present;
            data_q    <= in_data;
            eol_q     <= eol_in;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   for (genvar b = 0; b < NB; b++) begin : g_bank
      if (R1W1 != 0) begin : g_r1w1
         generic_dual_port_ram #(.DW(DW), .AW(AW)) u_ram (
            .clk   (clk),
            .we    (acc && (bank_eff == BW'(b))),
            .waddr (col_eff),
            .wdata (in_data),
            .re    (acc),
            .raddr (col_eff),
            .rdata (bank_rd[b*DW +: DW])
         );
      end else begin : g_1rw
         generic_single_port_ram_wrapper #(.DW(DW), .AW(AW)) u_ram (
            .clk   (clk),
            .en    (acc),
            .we    (bank_eff == BW'(b)),
            .addr  (col_eff),
            .wdata (in_data),
            .rdata (bank_rd[b*DW +: DW])
         );
      end
   end

   generic_lb_tap_rotator #(.NB(NB), .NO_LINES(NO_LINES), .DW(DW), .BW(BW)) u_rot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (acc),
      .sel       (bank_eff),
      .bank_data (bank_rd),
      .taps      (taps)
   );

   // Bank registers are not reset; gating keeps the output at zero whenever nothing is presented.
   assign out_data = out_valid ? {taps, data_q} : '0;
   assign out_eol  = out_valid & eol_q;

endmodule

// File: tb/tb_generic_line_buffer_ctrl.sv
// Scoreboard bench: a 1R1W and a 1RW instance run in lockstep on identical stimulus.
module tb_generic_line_buffer_ctrl;

   localparam int NL  = 2;
   localparam int DW  = 8;
   localparam int AW  = 2;
   localparam int IW  = 4;
   localparam int ODW = (NL + 1) * DW;

   logic clk = 1'b0, rst_n = 1'b1, sof = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic in_ready0, in_ready1, out_valid0, out_valid1, out_eol0, out_eol1;
   logic [ODW-1:0] out_data0, out_data1;

   typedef struct packed {
      logic [ODW-1:0] data;
      logic           eol;
   } exp_t;

   exp_t q0[$], q1[$];
   int checks = 0, fails = 0;
   int stall_cycles = 0;
   bit force_stall = 1'b0;
   bit mon_en = 1'b0;
   bit held_v[2];
   logic [ODW-1:0] held_d[2];
   int ncap[2];

   always #5 clk = ~clk;

   generic_line_buffer_ctrl #(.R1W1(1), .NO_LINES(NL), .DW(DW), .AW(AW), .IMG_W(IW)) dut0 (
      .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_eol(out_eol0));

   generic_line_buffer_ctrl #(.R1W1(0), .NO_LINES(NL), .DW(DW), .AW(AW), .IMG_W(IW)) dut1 (
      .clk(clk), .rst_n(rst_n), .sof(sof), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_eol(out_eol1));

   function automatic logic [7:0] pix(input int f, input int l, input int c);
      return 8'((f << 7) | (l << 4) | c);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mon(input int id, input logic v, input logic [ODW-1:0] d,
                      input logic e, input logic rdy);
      exp_t x;
      chk($sformatf("in_ready_rule[%0d]", id), 32'(rdy), 32'(!v || out_ready));
      if (held_v[id]) begin
         chk($sformatf("stall_valid_held[%0d]", id), 32'(v), 32'd1);
         chk($sformatf("stall_data_held[%0d]", id), 32'(d), 32'(held_d[id]));
      end
      if (v && out_ready) begin
         if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            checks++;
            fails++;
            $display("FAIL spurious_output[%0d]: got %h expected no beat at %0t", id, d, $time);
         end else begin
            if (id == 0) x = q0.pop_front();
            else         x = q1.pop_front();
            chk($sformatf("out_data[%0d]#%0d", id, ncap[id]), 32'(d), 32'(x.data));
            chk($sformatf("out_eol[%0d]#%0d", id, ncap[id]), 32'(e), 32'(x.eol));
            if (ncap[id] == 1)  chk($sformatf("prime_line2_col1[%0d]", id), 32'(d), 32'h011121);
            if (ncap[id] == 16) chk($sformatf("wrap_line6_col0[%0d]", id), 32'(d), 32'h405060);
            ncap[id]++;
         end
      end
      held_v[id] = v && !out_ready;
      held_d[id] = d;
   endtask

   initial forever begin
      @(negedge clk);
      #3;
      if (mon_en && rst_n) begin
         mon(0, out_valid0, out_data0, out_eol0, in_ready0);
         mon(1, out_valid1, out_data1, out_eol1, in_ready1);
      end
   end

   initial forever begin
      @(negedge clk);
      if (stall_cycles > 0) begin
         out_ready = 1'b0;
         stall_cycles--;
      end else begin
         out_ready = !force_stall;
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_in_ready0"}, 32'(in_ready0), 32'd0);
      chk({tag, "_in_ready1"}, 32'(in_ready1), 32'd0);
      chk({tag, "_out_valid0"}, 32'(out_valid0), 32'd0);
      chk({tag, "_out_valid1"}, 32'(out_valid1), 32'd0);
      chk({tag, "_out_data0"}, 32'(out_data0), 32'd0);
      chk({tag, "_out_data1"}, 32'(out_data1), 32'd0);
      chk({tag, "_out_eol0"}, 32'(out_eol0), 32'd0);
      chk({tag, "_out_eol1"}, 32'(out_eol1), 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #3;
      chk("ready_low_after_release0", 32'(in_ready0), 32'd0);
      chk("ready_low_after_release1", 32'(in_ready1), 32'd0);
      @(posedge clk);
      #1;
      chk("ready_high_first_cycle0", 32'(in_ready0), 32'd1);
      chk("ready_high_first_cycle1", 32'(in_ready1), 32'd1);
      held_v[0] = 1'b0;
      held_v[1] = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic send(input int f, input int l, input int c, input bit s);
      exp_t x;
      int waited;
      bit ok;
      waited = 0;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      sof      = s;
      in_data  = pix(f, l, c);
      forever begin
         #2;
         ok = in_ready0;
         chk("in_ready_lockstep", 32'(in_ready1), 32'(in_ready0));
         @(posedge clk);
         if (ok) break;
         waited++;
         if (waited >= 50) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: pixel f%0d l%0d c%0d not accepted in 50 cycles", f, l, c);
            break;
         end
         @(negedge clk);
      end
      if (ok && l >= NL) begin
         x.data = {pix(f, l - 2, c), pix(f, l - 1, c), pix(f, l, c)};
         x.eol  = (c == IW - 1);
         q0.push_back(x);
         q1.push_back(x);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      sof      = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      #1 check_zero("reset");
      repeat (2) @(negedge clk);
      release_reset();

      // frame 0: priming, 7-line bank wrap, 5-cycle stall mid line 3
      for (int l = 0; l < 7; l++) begin
         for (int c = 0; c < IW; c++) begin
            send(0, l, c, (l == 0 && c == 0));
            if (l == 3 && c == 1) stall_cycles = 5;
         end
      end

      // frame 1 cut short by sof at line 2 col 2 while a beat is pending
      for (int l = 0; l < 2; l++)
         for (int c = 0; c < IW; c++) send(1, l, c, (l == 0 && c == 0));
      send(1, 2, 0, 1'b0);
      send(1, 2, 1, 1'b0);
      stall_cycles = 2;

      // frame 2 starts with that sof beat; reset hits while a beat is stalled in line 3
      for (int l = 0; l < 3; l++)
         for (int c = 0; c < IW; c++) send(0, l, c, (l == 0 && c == 0));
      send(0, 3, 0, 1'b0);
      send(0, 3, 1, 1'b0);
      force_stall = 1'b1;
      idle();
      @(negedge clk);
      mon_en = 1'b0;
      #3;
      chk("pre_reset_valid0", 32'(out_valid0), 32'd1);
      chk("pre_reset_valid1", 32'(out_valid1), 32'd1);
      rst_n = 1'b0;
      #1 check_zero("async_reset");
      chk("pending_at_reset0", 32'(q0.size()), 32'd1);
      chk("pending_at_reset1", 32'(q1.size()), 32'd1);
      q0.delete();
      q1.delete();
      force_stall = 1'b0;
      release_reset();

      // frame 3 after reset must prime again from scratch
      for (int l = 0; l < 3; l++)
         for (int c = 0; c < IW; c++) send(1, l, c, (l == 0 && c == 0));
      idle();
      repeat (5) @(negedge clk);
      mon_en = 1'b0;

      chk("drain_q0", 32'(q0.size()), 32'd0);
      chk("drain_q1", 32'(q1.size()), 32'd0);
      chk("beat_count0", 32'(ncap[0]), 32'd31);
      chk("beat_count1", 32'(ncap[1]), 32'd31);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
